// File: rtl/execute_stage.sv
// -----------------------------------------------------------------------------
// execute_stage
//   EX stage of the five-stage 64-bit pipeline. Resolves operand forwarding
//   from the EX/MEM register and the WB stage, runs the ALU, evaluates beq,
//   and holds the EX/MEM pipeline register that feeds the memory stage.
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   id_ex_*                  instruction fields and control from ID/EX
//   mem_wb_rd/RegWrite/
//   mem_wb_wb_data           writeback forwarding source
//   stall                    hold the EX/MEM register
//   flush                    load a bubble into the EX/MEM register (wins
//                            over stall)
//   ex_mem_*                 registered EX/MEM outputs to the memory stage
// -----------------------------------------------------------------------------
module execute_stage #(
  parameter int XLEN  = 64,
  parameter int RADDR = 5
) (
  input  logic             clk,
  input  logic             rst,

  input  logic [XLEN-1:0]  id_ex_pc,
  input  logic [XLEN-1:0]  id_ex_rs1_data,
  input  logic [XLEN-1:0]  id_ex_rs2_data,
  input  logic [XLEN-1:0]  id_ex_imm,
  input  logic [RADDR-1:0] id_ex_rs1,
  input  logic [RADDR-1:0] id_ex_rs2,
  input  logic [RADDR-1:0] id_ex_rd,
  input  logic [3:0]       id_ex_alu_ctrl,
  input  logic             id_ex_ALUSrc,
  input  logic             id_ex_Branch,
  input  logic             id_ex_Memread,
  input  logic             id_ex_Memwrite,
  input  logic             id_ex_MemtoReg,
  input  logic             id_ex_Regwrite,

  input  logic [RADDR-1:0] mem_wb_rd,
  input  logic             mem_wb_RegWrite,
  input  logic [XLEN-1:0]  mem_wb_wb_data,

  input  logic             stall,
  input  logic             flush,

  output logic [RADDR-1:0] ex_mem_rd,
  output logic             ex_mem_Memwrite,
  output logic             ex_mem_Memread,
  output logic             ex_mem_MemtoReg,
  output logic             ex_mem_Regwrite,
  output logic [XLEN-1:0]  ex_mem_alu_result,
  output logic [XLEN-1:0]  ex_mem_rs2,
  output logic             ex_mem_branch_taken,
  output logic [XLEN-1:0]  ex_mem_branch_target
);

  localparam int SHW = $clog2(XLEN);

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_XOR  = 4'b0011;
  localparam logic [3:0] ALU_SLL  = 4'b0100;
  localparam logic [3:0] ALU_SRL  = 4'b0101;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SRA  = 4'b0111;
  localparam logic [3:0] ALU_SLT  = 4'b1000;
  localparam logic [3:0] ALU_SLTU = 4'b1001;

  // Forwarding mux for one source operand. EX/MEM beats WB; x0 is never
  // forwarded. A load in EX/MEM has no data yet (its alu_result is only the
  // address), so it is skipped and the hazard unit guarantees a bubble.
  function automatic logic [XLEN-1:0] fwd_sel(
    input logic [RADDR-1:0] rs,
    input logic [XLEN-1:0]  rf_val,
    input logic             exm_we,
    input logic             exm_load,
    input logic [RADDR-1:0] exm_rd,
    input logic [XLEN-1:0]  exm_val,
    input logic             wb_we,
    input logic [RADDR-1:0] wb_rd,
    input logic [XLEN-1:0]  wb_val
  );
    if (exm_we && !exm_load && (exm_rd != '0) && (exm_rd == rs))
      return exm_val;
    if (wb_we && (wb_rd != '0) && (wb_rd == rs))
      return wb_val;
    return rf_val;
  endfunction

  // ALU. Add/sub wrap; shifts use the low log2(XLEN) bits of B; set-less-than
  // results are zero-extended 0/1; unused encodings return 0.
  function automatic logic [XLEN-1:0] alu_op(
    input logic [3:0]      op,
    input logic [XLEN-1:0] a,
    input logic [XLEN-1:0] b
  );
    logic signed [XLEN-1:0] sa;
    logic signed [XLEN-1:0] sb;
    logic [SHW-1:0]         shamt;
    logic [XLEN-1:0]        res;
    sa    = $signed(a);
    sb    = $signed(b);
    shamt = b[SHW-1:0];
    res   = '0;
    case (op)
      ALU_AND:  res = a & b;
      ALU_OR:   res = a | b;
      ALU_ADD:  res = a + b;
      ALU_SUB:  res = a - b;
      ALU_XOR:  res = a ^ b;
      ALU_SLL:  res = a << shamt;
      ALU_SRL:  res = a >> shamt;
      ALU_SRA:  res = sa >>> shamt;
      ALU_SLT:  res = {{(XLEN-1){1'b0}}, (sa < sb)};
      ALU_SLTU: res = {{(XLEN-1){1'b0}}, (a < b)};
      default:  res = '0;
    endcase
    return res;
  endfunction

  // ---- stage p0: forwarding, ALU, branch (combinational from ID/EX and EX/MEM)
  logic [XLEN-1:0] fwd_a_p0;
  logic [XLEN-1:0] fwd_b_p0;
  logic [XLEN-1:0] op_b_p0;
  logic [XLEN-1:0] alu_res_p0;
  logic            taken_p0;
  logic [XLEN-1:0] target_p0;

  always_comb begin
    fwd_a_p0   = fwd_sel(id_ex_rs1, id_ex_rs1_data,
                         ex_mem_Regwrite, ex_mem_MemtoReg, ex_mem_rd,
                         ex_mem_alu_result,
                         mem_wb_RegWrite, mem_wb_rd, mem_wb_wb_data);
    fwd_b_p0   = fwd_sel(id_ex_rs2, id_ex_rs2_data,
                         ex_mem_Regwrite, ex_mem_MemtoReg, ex_mem_rd,
                         ex_mem_alu_result,
                         mem_wb_RegWrite, mem_wb_rd, mem_wb_wb_data);
    op_b_p0    = id_ex_ALUSrc ? id_ex_imm : fwd_b_p0;
    alu_res_p0 = alu_op(id_ex_alu_ctrl, fwd_a_p0, op_b_p0);
    // beq compares the forwarded registers directly, regardless of ALU op
    taken_p0   = id_ex_Branch && (fwd_a_p0 == fwd_b_p0);
    target_p0  = id_ex_pc + id_ex_imm;
  end

  // ---- stage p1: EX/MEM register (flush > stall > capture)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_mem_rd            <= '0;
      ex_mem_Memwrite      <= 1'b0;
      ex_mem_Memread       <= 1'b0;
      ex_mem_MemtoReg      <= 1'b0;
      ex_mem_Regwrite      <= 1'b0;
      ex_mem_alu_result    <= '0;
      ex_mem_rs2           <= '0;
      ex_mem_branch_taken  <= 1'b0;
      ex_mem_branch_target <= '0;
    end else if (flush) begin
      ex_mem_rd            <= '0;
      ex_mem_Memwrite      <= 1'b0;
      ex_mem_Memread       <= 1'b0;
      ex_mem_MemtoReg      <= 1'b0;
      ex_mem_Regwrite      <= 1'b0;
      ex_mem_alu_result    <= '0;
      ex_mem_rs2           <= '0;
      ex_mem_branch_taken  <= 1'b0;
      ex_mem_branch_target <= '0;
    end else if (!stall) begin
      ex_mem_rd            <= id_ex_rd;
      ex_mem_Memwrite      <= id_ex_Memwrite;
      ex_mem_Memread       <= id_ex_Memread;
      ex_mem_MemtoReg      <= id_ex_MemtoReg;
      ex_mem_Regwrite      <= id_ex_Regwrite;
      ex_mem_alu_result    <= alu_res_p0;
      ex_mem_rs2           <= fwd_b_p0;
      ex_mem_branch_taken  <= taken_p0;
      ex_mem_branch_target <= target_p0;
    end
  end

endmodule

// File: tb/tb_execute_stage.sv
// -----------------------------------------------------------------------------
// tb_execute_stage
//   Directed-vector bench for execute_stage: reset, ALU sweep, forwarding
//   priority, store data forwarding, beq, stall and flush.
// -----------------------------------------------------------------------------
module tb_execute_stage;
  localparam int XLEN  = 64;
  localparam int RADDR = 5;

  localparam logic [3:0] ADD = 4'b0010, SUB = 4'b0110, AND_ = 4'b0000,
                         OR_ = 4'b0001, XOR_ = 4'b0011, SLL = 4'b0100,
                         SRL = 4'b0101, SRA = 4'b0111, SLT = 4'b1000,
                         SLTU = 4'b1001, BAD = 4'b1111;

  // flags = {ALUSrc, Branch, Memread, Memwrite, MemtoReg, Regwrite}
  localparam logic [5:0] F_RW  = 6'b000001, F_M2R = 6'b000010,
                         F_MW  = 6'b000100, F_MR  = 6'b001000,
                         F_BR  = 6'b010000, F_SRC = 6'b100000;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [XLEN-1:0]  id_ex_pc, id_ex_rs1_data, id_ex_rs2_data, id_ex_imm;
  logic [RADDR-1:0] id_ex_rs1, id_ex_rs2, id_ex_rd;
  logic [3:0]       id_ex_alu_ctrl;
  logic             id_ex_ALUSrc, id_ex_Branch, id_ex_Memread, id_ex_Memwrite;
  logic             id_ex_MemtoReg, id_ex_Regwrite;
  logic [RADDR-1:0] mem_wb_rd;
  logic             mem_wb_RegWrite;
  logic [XLEN-1:0]  mem_wb_wb_data;
  logic             stall, flush;
  logic [RADDR-1:0] ex_mem_rd;
  logic             ex_mem_Memwrite, ex_mem_Memread, ex_mem_MemtoReg, ex_mem_Regwrite;
  logic [XLEN-1:0]  ex_mem_alu_result, ex_mem_rs2, ex_mem_branch_target;
  logic             ex_mem_branch_taken;

  execute_stage #(.XLEN(XLEN), .RADDR(RADDR)) dut (
    .clk(clk), .rst(rst),
    .id_ex_pc(id_ex_pc), .id_ex_rs1_data(id_ex_rs1_data),
    .id_ex_rs2_data(id_ex_rs2_data), .id_ex_imm(id_ex_imm),
    .id_ex_rs1(id_ex_rs1), .id_ex_rs2(id_ex_rs2), .id_ex_rd(id_ex_rd),
    .id_ex_alu_ctrl(id_ex_alu_ctrl), .id_ex_ALUSrc(id_ex_ALUSrc),
    .id_ex_Branch(id_ex_Branch), .id_ex_Memread(id_ex_Memread),
    .id_ex_Memwrite(id_ex_Memwrite), .id_ex_MemtoReg(id_ex_MemtoReg),
    .id_ex_Regwrite(id_ex_Regwrite),
    .mem_wb_rd(mem_wb_rd), .mem_wb_RegWrite(mem_wb_RegWrite),
    .mem_wb_wb_data(mem_wb_wb_data),
    .stall(stall), .flush(flush),
    .ex_mem_rd(ex_mem_rd), .ex_mem_Memwrite(ex_mem_Memwrite),
    .ex_mem_Memread(ex_mem_Memread), .ex_mem_MemtoReg(ex_mem_MemtoReg),
    .ex_mem_Regwrite(ex_mem_Regwrite), .ex_mem_alu_result(ex_mem_alu_result),
    .ex_mem_rs2(ex_mem_rs2), .ex_mem_branch_taken(ex_mem_branch_taken),
    .ex_mem_branch_target(ex_mem_branch_target)
  );

  always #5 clk = ~clk;

  // {Memwrite, Memread, MemtoReg, Regwrite}
  logic [3:0] ctl;
  assign ctl = {ex_mem_Memwrite, ex_mem_Memread, ex_mem_MemtoReg, ex_mem_Regwrite};

  int n_vec  = 0;
  int n_miss = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%h expected 0x%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic op(input logic [63:0] pc, input logic [63:0] a, input logic [63:0] b,
                    input logic [63:0] imm, input logic [4:0] r1, input logic [4:0] r2,
                    input logic [4:0] rd, input logic [3:0] ctrl, input logic [5:0] f);
    id_ex_pc       = pc;
    id_ex_rs1_data = a;
    id_ex_rs2_data = b;
    id_ex_imm      = imm;
    id_ex_rs1      = r1;
    id_ex_rs2      = r2;
    id_ex_rd       = rd;
    id_ex_alu_ctrl = ctrl;
    {id_ex_ALUSrc, id_ex_Branch, id_ex_Memread, id_ex_Memwrite,
     id_ex_MemtoReg, id_ex_Regwrite} = f;
  endtask

  task automatic wb(input logic [4:0] rd, input logic we, input logic [63:0] data);
    mem_wb_rd       = rd;
    mem_wb_RegWrite = we;
    mem_wb_wb_data  = data;
  endtask

  // ALU sweep: entries 0..7 use A=10, B=90; entries 8..12 use
  // A=0x8000_0000_0000_0000, B=0x44 (shift amount 4 from B[5:0]).
  logic [3:0]  sw_op  [13] = '{ADD, SUB, SLT, SLTU, AND_, OR_, XOR_, BAD,
                               SRA, SRL, SLL, SLT, SLTU};
  logic [63:0] sw_exp [13] = '{64'd100, 64'hFFFF_FFFF_FFFF_FFB0, 64'd1, 64'd1,
                               64'd10, 64'd90, 64'd80, 64'd0,
                               64'hF800_0000_0000_0000, 64'h0800_0000_0000_0000,
                               64'd0, 64'd1, 64'd0};

  initial begin
    // Reset with every input nonzero (stall/flush must stay low to capture)
    op(64'h100, 64'd5, 64'd3, 64'h10, 5'd1, 5'd2, 5'd3, ADD, 6'b111111);
    wb(5'd9, 1'b1, 64'h77);
    stall = 1'b0;
    flush = 1'b0;
    #1 rst = 1'b1;
    #1;
    chk("reset_alu",    ex_mem_alu_result,    64'd0);
    chk("reset_rs2",    ex_mem_rs2,           64'd0);
    chk("reset_rd",     ex_mem_rd,            64'd0);
    chk("reset_ctl",    ctl,                  64'd0);
    chk("reset_taken",  ex_mem_branch_taken,  64'd0);
    chk("reset_target", ex_mem_branch_target, 64'd0);
    #1 rst = 1'b0;
    tick();
    chk("first_alu",    ex_mem_alu_result,    64'h15);
    chk("first_rs2",    ex_mem_rs2,           64'd3);
    chk("first_rd",     ex_mem_rd,            64'd3);
    chk("first_ctl",    ctl,                  64'hF);
    chk("first_taken",  ex_mem_branch_taken,  64'd0);
    chk("first_target", ex_mem_branch_target, 64'h110);

    // ALU sweep, no hazards
    wb(5'd0, 1'b0, 64'd0);
    for (int i = 0; i < 13; i++) begin
      if (i < 8) op(64'd0, 64'd10, 64'd90, 64'd0, 5'd1, 5'd2, 5'd10, sw_op[i], F_RW);
      else       op(64'd0, 64'h8000_0000_0000_0000, 64'h44, 64'd0, 5'd1, 5'd2, 5'd10, sw_op[i], F_RW);
      tick();
      chk($sformatf("alu_sweep_%0d_op%b", i, sw_op[i]), ex_mem_alu_result, sw_exp[i]);
    end

    // Forwarding priority
    op(64'd0, 64'd3, 64'd4, 64'd0, 5'd1, 5'd2, 5'd5, ADD, F_RW);
    tick();
    chk("add_x5", ex_mem_alu_result, 64'd7);
    wb(5'd5, 1'b1, 64'd3);
    op(64'd0, 64'h99, 64'd0, 64'd0, 5'd5, 5'd2, 5'd11, ADD, F_RW);
    tick();
    chk("fwd_exmem_over_wb", ex_mem_alu_result, 64'd7);
    op(64'd0, 64'd3, 64'd4, 64'd0, 5'd1, 5'd2, 5'd0, ADD, F_RW);
    tick();
    chk("rd0_captured", ex_mem_rd, 64'd0);
    op(64'd0, 64'h99, 64'd0, 64'd0, 5'd5, 5'd2, 5'd0, ADD, F_RW);
    tick();
    chk("fwd_wb_exmem_rd0", ex_mem_alu_result, 64'd3);
    wb(5'd0, 1'b1, 64'd3);
    op(64'd0, 64'h55, 64'd0, 64'd0, 5'd0, 5'd2, 5'd13, ADD, F_RW);
    tick();
    chk("no_fwd_x0", ex_mem_alu_result, 64'h55);

    // Load in EX/MEM must not forward
    wb(5'd5, 1'b1, 64'd3);
    op(64'd0, 64'd0, 64'd0, 64'h200, 5'd1, 5'd2, 5'd5, ADD, F_SRC | F_MR | F_M2R | F_RW);
    tick();
    chk("load_addr", ex_mem_alu_result, 64'h200);
    chk("load_ctl",  ctl,               64'h7);
    op(64'd0, 64'h99, 64'd0, 64'd0, 5'd5, 5'd2, 5'd14, ADD, F_RW);
    tick();
    chk("no_fwd_from_load", ex_mem_alu_result, 64'd3);

    // Store with rs2 forwarded from WB
    wb(5'd6, 1'b1, 64'h1234);
    op(64'd0, 64'd16, 64'hDEAD, 64'd8, 5'd7, 5'd6, 5'd0, ADD, F_SRC | F_MW);
    tick();
    chk("store_addr", ex_mem_alu_result, 64'd24);
    chk("store_data", ex_mem_rs2,        64'h1234);
    chk("store_ctl",  ctl,               64'h8);

    // beq
    wb(5'd0, 1'b0, 64'd0);
    op(64'h40, 64'd6, 64'd6, 64'hFFFF_FFFF_FFFF_FFF8, 5'd1, 5'd2, 5'd0, SUB, F_BR);
    tick();
    chk("beq_taken",  ex_mem_branch_taken,  64'd1);
    chk("beq_target", ex_mem_branch_target, 64'h38);
    op(64'h44, 64'd6, 64'd6, 64'd0, 5'd1, 5'd2, 5'd0, ADD, 6'd0);
    tick();
    chk("beq_pulse_ends", ex_mem_branch_taken, 64'd0);
    op(64'h40, 64'd6, 64'd5, 64'hFFFF_FFFF_FFFF_FFF8, 5'd1, 5'd2, 5'd0, SUB, F_BR);
    tick();
    chk("beq_not_taken", ex_mem_branch_taken,  64'd0);
    chk("beq_nt_target", ex_mem_branch_target, 64'h38);
    op(64'd0, 64'd4, 64'd5, 64'd0, 5'd1, 5'd2, 5'd8, ADD, F_RW);
    tick();
    op(64'h100, 64'd9, 64'd0, 64'h20, 5'd3, 5'd8, 5'd0, AND_, F_BR);
    tick();
    chk("beq_fwd_taken", ex_mem_branch_taken, 64'd1);
    chk("rs2_fwd_exmem", ex_mem_rs2,          64'd9);

    // Stall holds outputs for 3 cycles, then forwarding sees the held result
    op(64'h80, 64'h18, 64'h18, 64'h10, 5'd1, 5'd2, 5'd9, ADD, F_BR | F_RW);
    tick();
    chk("pre_stall_alu", ex_mem_alu_result, 64'h30);
    stall = 1'b1;
    op(64'd0, 64'd0, 64'd1, 64'd0, 5'd9, 5'd2, 5'd15, ADD, F_RW);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("stall%0d_alu", i),    ex_mem_alu_result,    64'h30);
      chk($sformatf("stall%0d_rd", i),     ex_mem_rd,            64'd9);
      chk($sformatf("stall%0d_taken", i),  ex_mem_branch_taken,  64'd1);
      chk($sformatf("stall%0d_target", i), ex_mem_branch_target, 64'h90);
    end
    stall = 1'b0;
    tick();
    chk("post_stall_alu",   ex_mem_alu_result,   64'h31);
    chk("post_stall_rd",    ex_mem_rd,           64'd15);
    chk("post_stall_taken", ex_mem_branch_taken, 64'd0);

    // Flush together with stall: flush wins
    op(64'h200, 64'd2, 64'd2, 64'd0, 5'd1, 5'd2, 5'd7, OR_, F_MR | F_M2R | F_RW | F_BR);
    flush = 1'b1;
    stall = 1'b1;
    tick();
    chk("flush_rd",     ex_mem_rd,            64'd0);
    chk("flush_ctl",    ctl,                  64'd0);
    chk("flush_taken",  ex_mem_branch_taken,  64'd0);
    chk("flush_alu",    ex_mem_alu_result,    64'd0);
    chk("flush_rs2",    ex_mem_rs2,           64'd0);
    chk("flush_target", ex_mem_branch_target, 64'd0);
    flush = 1'b0;
    stall = 1'b0;
    tick();
    chk("after_flush_alu",   ex_mem_alu_result,   64'd2);
    chk("after_flush_rd",    ex_mem_rd,           64'd7);
    chk("after_flush_ctl",   ctl,                 64'h7);
    chk("after_flush_taken", ex_mem_branch_taken, 64'd1);

    // Asynchronous reset mid-operation
    #2 rst = 1'b1;
    #1;
    chk("midreset_alu",   ex_mem_alu_result,   64'd0);
    chk("midreset_rd",    ex_mem_rd,           64'd0);
    chk("midreset_ctl",   ctl,                 64'd0);
    chk("midreset_taken", ex_mem_branch_taken, 64'd0);
    rst = 1'b0;
    tick();
    chk("post_reset_alu", ex_mem_alu_result, 64'd2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
